// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receive FSM states and default oversampling.
// Used by both the Rx and Tx sides of the link.
package uart_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic parity_enabled(logic [1:0] par);
    return (par == PAR_ODD) || (par == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Receiver-side bundle: line, tick and frame controls in; character and status out.
interface uart_rx_sipo_if;

  logic       SampleTick;
  logic       SerialIn;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       DataLength;
  logic [7:0] DataOut;
  logic       ParityError;
  logic       StopError;
  logic       ActiveFlag;
  logic       DoneFlag;

  modport master (
    output SampleTick, SerialIn, ParityType, StopBits, DataLength,
    input  DataOut, ParityError, StopError, ActiveFlag, DoneFlag
  );

  modport slave (
    input  SampleTick, SerialIn, ParityType, StopBits, DataLength,
    output DataOut, ParityError, StopError, ActiveFlag, DoneFlag
  );

endinterface

// File: rtl/uart_rx_sync.sv
// N-stage synchronizer for the asynchronous serial line plus a falling-edge detector.
// Everything resets to the idle (high) line level.
module uart_rx_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic SerialIn,
  output logic RxS,
  output logic FallEdge
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], SerialIn};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign RxS      = sync_q[Stages-1];
  assign FallEdge = prev_q & ~RxS;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART serial-in/parallel-out receiver: start/data/parity/stop recovery with oversampling,
// frame format latched at start-bit detection, results held until the next completed frame.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  uart_rx_sipo_if.slave rx
);

  localparam int unsigned      TickW   = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);

  logic rx_s, fall_edge;

  uart_rx_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .SerialIn(rx.SerialIn),
    .RxS     (rx_s),
    .FallEdge(fall_edge)
  );

  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       par_cfg_q, par_cfg_d;
  logic             stop_cfg_q, stop_cfg_d;
  logic             len_cfg_q, len_cfg_d;
  logic             par_pend_q, par_pend_d;
  logic             stop_pend_q, stop_pend_d;
  logic [7:0]       data_q, data_d;
  logic             par_err_q, par_err_d;
  logic             stop_err_q, stop_err_d;
  logic             done_q, done_d;
  logic             at_centre;

  // Mid-bit in START, bit centre everywhere else.
  assign at_centre = rx.SampleTick && (tick_q == ((state_q == StStart) ? TickMid : TickEnd));

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_cfg_d   = par_cfg_q;
    stop_cfg_d  = stop_cfg_q;
    len_cfg_d   = len_cfg_q;
    par_pend_d  = par_pend_q;
    stop_pend_d = stop_pend_q;
    data_d      = data_q;
    par_err_d   = par_err_q;
    stop_err_d  = stop_err_q;
    done_d      = 1'b0;

    if (state_q != StIdle && rx.SampleTick && !at_centre) begin
      tick_d = tick_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fall_edge) begin
          state_d     = StStart;
          tick_d      = '0;
          bit_d       = '0;
          shift_d     = '0;
          par_cfg_d   = rx.ParityType;
          stop_cfg_d  = rx.StopBits;
          len_cfg_d   = rx.DataLength;
          par_pend_d  = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      StStart: begin
        if (at_centre) begin
          tick_d  = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (at_centre) begin
          tick_d         = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == (len_cfg_q ? 3'd7 : 3'd6)) begin
            bit_d   = '0;
            state_d = parity_enabled(par_cfg_q) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (at_centre) begin
          tick_d     = '0;
          // Bit 7 is still zero in 7-bit mode, so the full-width XOR is correct.
          par_pend_d = ((^shift_q) ^ rx_s) != (par_cfg_q == PAR_ODD);
          state_d    = StStop;
        end
      end
      StStop: begin
        if (at_centre) begin
          tick_d = '0;
          if (!rx_s) begin
            stop_pend_d = 1'b1;
          end
          if (bit_q[0] == stop_cfg_q) begin
            data_d     = shift_q;
            par_err_d  = par_pend_q;
            stop_err_d = stop_pend_q | ~rx_s;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_cfg_q   <= PAR_NONE0;
      stop_cfg_q  <= 1'b0;
      len_cfg_q   <= 1'b0;
      par_pend_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_cfg_q   <= par_cfg_d;
      stop_cfg_q  <= stop_cfg_d;
      len_cfg_q   <= len_cfg_d;
      par_pend_q  <= par_pend_d;
      stop_pend_q <= stop_pend_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
      done_q      <= done_d;
    end
  end

  assign rx.DataOut     = data_q;
  assign rx.ParityError = par_err_q;
  assign rx.StopError   = stop_err_q;
  assign rx.DoneFlag    = done_q;
  // Stays high through the DoneFlag cycle even though the FSM is already idle.
  assign rx.ActiveFlag  = (state_q != StIdle) | done_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: table-driven frames plus hand-written corner sequences,
// with a scoreboard that checks every completed frame.
module tb_uart_rx_sipo;
  import uart_pkg::*;

  localparam int unsigned Os      = 16;
  localparam int          TickDiv = 4;
  localparam int          BitClks = Os * TickDiv;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  typedef struct {
    logic [1:0] par;
    logic       stop2;
    logic       len8;
    logic [7:0] data;
    logic       flip;
    logic       stop_bad;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset;

  uart_rx_sipo_if bus ();

  uart_rx_sipo #(
    .OVERSAMPLE (Os),
    .SYNC_STAGES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .rx   (bus)
  );

  always #5 Clock = ~Clock;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   active_cnt = 0;
  exp_t exp_q[$];
  vec_t vecs[9];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic par_on(input logic [1:0] par);
    return (par == 2'b01) || (par == 2'b10);
  endfunction

  initial begin
    bus.SampleTick = 1'b0;
    forever begin
      repeat (TickDiv - 1) @(negedge Clock);
      bus.SampleTick = 1'b1;
      @(negedge Clock);
      bus.SampleTick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  // Scoreboard consumer: every DoneFlag cycle pops one expected frame.
  always @(negedge Clock) begin
    exp_t e;
    if (bus.ActiveFlag === 1'b1) active_cnt++;
    if (bus.DoneFlag === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DoneFlag with data %0h, required no frame",
                 bus.DataOut);
      end else begin
        e = exp_q.pop_front();
        check("data_out", int'(bus.DataOut), int'(e.data));
        check("parity_error", int'(bus.ParityError), int'(e.perr));
        check("stop_error", int'(bus.StopError), int'(e.serr));
      end
    end
  end

  task automatic idle(input int nbits);
    bus.SerialIn = 1'b1;
    repeat (nbits * BitClks) @(negedge Clock);
  endtask

  task automatic send_bit(input logic b);
    bus.SerialIn = b;
    repeat (BitClks) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [1:0] par, input logic stop2, input logic len8,
                            input logic [7:0] data, input logic flip, input logic stop_bad,
                            input logic mid_change);
    logic [7:0] d;
    logic       p;
    int         nd;
    d  = len8 ? data : {1'b0, data[6:0]};
    nd = len8 ? 8 : 7;
    p  = ^d;
    if (par == 2'b01) p = ~p;
    p = p ^ flip;
    bus.ParityType = par;
    bus.StopBits   = stop2;
    bus.DataLength = len8;
    send_bit(1'b0);
    for (int i = 0; i < nd; i++) begin
      send_bit(d[i]);
      if (mid_change && i == 2) begin
        bus.ParityType = 2'b01;
        bus.StopBits   = 1'b1;
        bus.DataLength = 1'b0;
      end
    end
    if (par_on(par)) send_bit(p);
    send_bit(~stop_bad);
    if (stop2) send_bit(1'b1);
  endtask

  task automatic push_exp(input logic [7:0] data, input logic perr, input logic serr);
    exp_t e;
    e.data = data;
    e.perr = perr;
    e.serr = serr;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 4 * BitClks && done_cnt < target; i++) @(negedge Clock);
    check("done_count", done_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, int'(bus.DataOut), 0);
    check({tag, "_perr"}, int'(bus.ParityError), 0);
    check({tag, "_serr"}, int'(bus.StopError), 0);
    check({tag, "_active"}, int'(bus.ActiveFlag), 0);
    check({tag, "_done"}, int'(bus.DoneFlag), 0);
  endtask

  initial begin
    int         target;
    int         nbits;
    logic [7:0] last_data;

    //           par        st2   len8  data   flip  sbad  exp    perr  serr
    vecs[0] = '{PAR_NONE0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{PAR_ODD,   1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[2] = '{PAR_ODD,   1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0};
    vecs[3] = '{PAR_EVEN,  1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{PAR_EVEN,  1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{PAR_NONE0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{PAR_ODD,   1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{PAR_NONE3, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[8] = '{PAR_NONE0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1};

    bus.SerialIn   = 1'b1;
    bus.ParityType = PAR_NONE0;
    bus.StopBits   = 1'b0;
    bus.DataLength = 1'b1;
    Reset          = 1'b1;
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset");
    Reset = 1'b0;
    idle(2);

    for (int k = 0; k < 9; k++) begin
      push_exp(vecs[k].exp_data, vecs[k].exp_perr, vecs[k].exp_serr);
      target     = done_cnt + 1;
      active_cnt = 0;
      send_frame(vecs[k].par, vecs[k].stop2, vecs[k].len8, vecs[k].data, vecs[k].flip,
                 vecs[k].stop_bad, 1'b0);
      idle(2);
      wait_done(target);
      nbits = 1 + (vecs[k].len8 ? 8 : 7) + (par_on(vecs[k].par) ? 1 : 0) + (vecs[k].stop2 ? 2 : 1);
      check("active_len", int'(active_cnt >= (nbits - 1) * BitClks && active_cnt <= nbits * BitClks),
            1);
      check("active_idle", int'(bus.ActiveFlag), 0);
    end

    // Stop error with the line left low: no retrigger until a fresh falling edge.
    push_exp(8'h3C, 1'b0, 1'b1);
    target = done_cnt + 1;
    send_frame(PAR_EVEN, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    bus.SerialIn = 1'b0;
    repeat (4 * BitClks) @(negedge Clock);
    wait_done(target);
    check("stuck_low_active", int'(bus.ActiveFlag), 0);
    idle(2);
    check("stuck_low_no_retrigger", done_cnt, target);
    push_exp(8'h6E, 1'b0, 1'b0);
    send_frame(PAR_NONE0, 1'b0, 1'b1, 8'h6E, 1'b0, 1'b0, 1'b0);
    idle(2);
    wait_done(target + 1);
    last_data = 8'h6E;

    // Short low glitch: false start.
    active_cnt   = 0;
    target       = done_cnt;
    bus.SerialIn = 1'b0;
    repeat (4 * TickDiv) @(negedge Clock);
    idle(2);
    check("glitch_active_brief", int'(active_cnt > 0 && active_cnt < BitClks), 1);
    check("glitch_no_done", done_cnt, target);
    check("glitch_data_held", int'(bus.DataOut), int'(last_data));
    check("glitch_active_idle", int'(bus.ActiveFlag), 0);

    // Reset in the middle of the data bits of 8'hFF.
    bus.ParityType = PAR_NONE0;
    bus.StopBits   = 1'b0;
    bus.DataLength = 1'b1;
    target         = done_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    check_reset_outputs("midreset");
    Reset = 1'b0;
    idle(8);
    check("midreset_no_done", done_cnt, target);
    push_exp(8'h12, 1'b0, 1'b0);
    send_frame(PAR_NONE0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    idle(2);
    wait_done(target + 1);

    // Back-to-back frames, 8N2 then 8N1 with a mid-frame config change.
    target = done_cnt + 2;
    push_exp(8'h01, 1'b0, 1'b0);
    push_exp(8'h80, 1'b0, 1'b0);
    send_frame(PAR_NONE0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    send_frame(PAR_NONE0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    idle(3);
    wait_done(target);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
